// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
package ser_pkg;

   // Controller states: waiting for a word, shifting bits out, inter-word idle gap.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   // Gap counter width; GAP_CYCLES is limited to 0..255.
   localparam int unsigned GapCntW = 8;

   // Bit-counter width for a word of the given size (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle for the bit serializer.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_bit;
   logic             out_valid;
   logic             word_done;
   logic             busy;

   // Word source / serial sink side.
   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_bit,
      input  out_valid,
      input  word_done,
      input  busy
   );

   // Serializer side.
   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_bit,
      output out_valid,
      output word_done,
      output busy
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and
// shifts them out one bit per clock, with an optional idle gap between words.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0,
   parameter bit          IDLE_BIT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   bit_serializer_if.slave  bus
);

   localparam int unsigned         CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0]     LastBit = CntW'(WIDTH - 1);
   localparam bit                  HasGap  = (GAP_CYCLES != 0);
   localparam logic [GapCntW-1:0]  GapLoad = HasGap ? GapCntW'(GAP_CYCLES - 1) : '0;

   ser_state_t           r_state;
   logic [WIDTH-1:0]     r_shreg;
   logic [CntW-1:0]      r_bit_cnt;
   logic [GapCntW-1:0]   r_gap_cnt;

   ser_state_t           w_state_nxt;
   logic [WIDTH-1:0]     w_shreg_nxt;
   logic [CntW-1:0]      w_bit_cnt_nxt;
   logic [GapCntW-1:0]   w_gap_cnt_nxt;

   logic                 w_last;
   logic                 w_ready;
   logic [WIDTH-1:0]     w_shifted;

   assign w_last  = (r_state == SHIFT) && (r_bit_cnt == LastBit);
   // A new word may enter in the same cycle the last bit leaves only when no gap follows.
   assign w_ready = (r_state == IDLE) || (w_last && !HasGap);

   assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

   // State register and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // Next-state logic: accept, shift, gap countdown.
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_gap_cnt_nxt = r_gap_cnt;
      unique case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt   = SHIFT;
               w_shreg_nxt   = bus.in_data;
               w_bit_cnt_nxt = '0;
            end
         end
         SHIFT: begin
            if (!w_last) begin
               w_shreg_nxt   = w_shifted;
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end else if (HasGap) begin
               w_state_nxt   = GAP;
               w_gap_cnt_nxt = GapLoad;
            end else if (bus.in_valid) begin
               // Back-to-back word: reload without leaving SHIFT.
               w_shreg_nxt   = bus.in_data;
               w_bit_cnt_nxt = '0;
            end else begin
               w_state_nxt   = IDLE;
            end
         end
         GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt   = IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = (r_state == SHIFT);
   assign bus.out_bit   = (r_state == SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                                             : IDLE_BIT;
   assign bus.word_done = w_last;
   assign bus.busy      = (r_state != IDLE);

endmodule
